// File: rtl/rv32imf_apu_core_pkg.sv
// Shared APU responder constants and the reorder-buffer entry layout.
package rv32imf_apu_core_pkg;

  localparam int unsigned APU_WOP_W           = 6;
  localparam int unsigned APU_NDSFLAGS_W      = 15;
  localparam int unsigned APU_NUSFLAGS_W      = 5;
  localparam int unsigned APU_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic                      alloc;
    logic                      done;
    logic [31:0]               result;
    logic [APU_NUSFLAGS_W-1:0] flags;
  } apu_rob_entry_t;

endpackage

// File: rtl/rv32imf_apu_rob.sv
// In-order reorder buffer: tagged out-of-order completion, strictly in-order retire.
module rv32imf_apu_rob
  import rv32imf_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = APU_MAX_OUTSTANDING,
  localparam int unsigned TAG_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc,
  input  logic                      rsp_valid,
  input  logic [TAG_W-1:0]          rsp_tag,
  input  logic [31:0]               rsp_result,
  input  logic [APU_NUSFLAGS_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]          wr_ptr,
  output logic [CNT_W-1:0]          count,
  output logic                      retire_c,
  output logic                      rsp_err_c,
  output logic [31:0]               head_result,
  output logic [APU_NUSFLAGS_W-1:0] head_flags
);

  apu_rob_entry_t [DEPTH-1:0] rob_q;
  logic [TAG_W-1:0]           wr_ptr_q;
  logic [TAG_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       rsp_ok;

  // Retire only looks at registered state, so a completion lands one cycle before it can leave.
  assign retire_c    = rob_q[rd_ptr_q].alloc & rob_q[rd_ptr_q].done;
  assign head_result = rob_q[rd_ptr_q].result;
  assign head_flags  = rob_q[rd_ptr_q].flags;
  assign rsp_ok      = rob_q[rsp_tag].alloc & ~rob_q[rsp_tag].done;
  assign rsp_err_c   = rsp_valid & ~rsp_ok;
  assign wr_ptr      = wr_ptr_q;
  assign count       = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (alloc) begin
        rob_q[wr_ptr_q].alloc <= 1'b1;
        rob_q[wr_ptr_q].done  <= 1'b0;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (rsp_valid && rsp_ok) begin
        rob_q[rsp_tag].done   <= 1'b1;
        rob_q[rsp_tag].result <= rsp_result;
        rob_q[rsp_tag].flags  <= rsp_flags;
      end
      if (retire_c) begin
        rob_q[rd_ptr_q].alloc <= 1'b0;
        rob_q[rd_ptr_q].done  <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + 1'b1;
      end
      case ({alloc, retire_c})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rv32imf_apu_responder.sv
// APU req/gnt/rvalid responder: grants core requests, tags them to the FPU, returns results in order.
module rv32imf_apu_responder
  import rv32imf_apu_core_pkg::*;
#(
  parameter int unsigned APU_WOP_CPU      = APU_WOP_W,
  parameter int unsigned APU_NDSFLAGS_CPU = APU_NDSFLAGS_W,
  parameter int unsigned APU_NUSFLAGS_CPU = APU_NUSFLAGS_W,
  parameter int unsigned MAX_OUTSTANDING  = APU_MAX_OUTSTANDING,
  localparam int unsigned TAG_W = $clog2(MAX_OUTSTANDING),
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        apu_req_i,
  output logic                        apu_gnt_o,
  input  logic [APU_WOP_CPU-1:0]      apu_op_i,
  input  logic [2:0][31:0]            apu_operands_i,
  input  logic [APU_NDSFLAGS_CPU-1:0] apu_flags_i,
  output logic                        apu_rvalid_o,
  output logic [31:0]                 apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0] apu_flags_o,
  output logic                        fpu_req_valid_o,
  input  logic                        fpu_req_ready_i,
  output logic [APU_WOP_CPU-1:0]      fpu_op_o,
  output logic [2:0][31:0]            fpu_operands_o,
  output logic [APU_NDSFLAGS_CPU-1:0] fpu_flags_o,
  output logic [TAG_W-1:0]            fpu_tag_o,
  input  logic                        fpu_rsp_valid_i,
  input  logic [TAG_W-1:0]            fpu_rsp_tag_i,
  input  logic [31:0]                 fpu_rsp_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0] fpu_rsp_flags_i,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  logic [CNT_W-1:0]          count;
  logic                      retire_c;
  logic                      rsp_err_c;
  logic [31:0]               head_result;
  logic [APU_NUSFLAGS_W-1:0] head_flags;

  // Full check uses the registered count, so a same-cycle retire never frees a slot early.
  assign fpu_req_valid_o = apu_req_i & (count < CNT_W'(MAX_OUTSTANDING));
  assign apu_gnt_o       = fpu_req_valid_o & fpu_req_ready_i;
  assign fpu_op_o        = apu_op_i;
  assign fpu_operands_o  = apu_operands_i;
  assign fpu_flags_o     = apu_flags_i;
  assign busy_o          = (count != '0) | apu_rvalid_o;

  rv32imf_apu_rob #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rob (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (apu_gnt_o),
    .rsp_valid   (fpu_rsp_valid_i),
    .rsp_tag     (fpu_rsp_tag_i),
    .rsp_result  (fpu_rsp_result_i),
    .rsp_flags   (APU_NUSFLAGS_W'(fpu_rsp_flags_i)),
    .wr_ptr      (fpu_tag_o),
    .count       (count),
    .retire_c    (retire_c),
    .rsp_err_c   (rsp_err_c),
    .head_result (head_result),
    .head_flags  (head_flags)
  );

  // Result registers hold their value until the next retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apu_rvalid_o <= 1'b0;
      apu_result_o <= '0;
      apu_flags_o  <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      apu_rvalid_o <= retire_c;
      if (retire_c) begin
        apu_result_o <= head_result;
        apu_flags_o  <= APU_NUSFLAGS_CPU'(head_flags);
      end
      proto_err_o <= proto_err_o | rsp_err_c;
    end
  end

endmodule

// File: tb/tb_rv32imf_apu_responder.sv
// Directed bench for the APU responder: in-order return, full/back-pressure, protocol errors, reset.
module tb_rv32imf_apu_responder;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            apu_req_i;
  logic            apu_gnt_o;
  logic [5:0]      apu_op_i;
  logic [2:0][31:0] apu_operands_i;
  logic [14:0]     apu_flags_i;
  logic            apu_rvalid_o;
  logic [31:0]     apu_result_o;
  logic [4:0]      apu_flags_o;
  logic            fpu_req_valid_o;
  logic            fpu_req_ready_i;
  logic [5:0]      fpu_op_o;
  logic [2:0][31:0] fpu_operands_o;
  logic [14:0]     fpu_flags_o;
  logic            fpu_tag_o;
  logic            fpu_rsp_valid_i;
  logic            fpu_rsp_tag_i;
  logic [31:0]     fpu_rsp_result_i;
  logic [4:0]      fpu_rsp_flags_i;
  logic            busy_o;
  logic            proto_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32imf_apu_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .apu_req_i        (apu_req_i),
    .apu_gnt_o        (apu_gnt_o),
    .apu_op_i         (apu_op_i),
    .apu_operands_i   (apu_operands_i),
    .apu_flags_i      (apu_flags_i),
    .apu_rvalid_o     (apu_rvalid_o),
    .apu_result_o     (apu_result_o),
    .apu_flags_o      (apu_flags_o),
    .fpu_req_valid_o  (fpu_req_valid_o),
    .fpu_req_ready_i  (fpu_req_ready_i),
    .fpu_op_o         (fpu_op_o),
    .fpu_operands_o   (fpu_operands_o),
    .fpu_flags_o      (fpu_flags_o),
    .fpu_tag_o        (fpu_tag_o),
    .fpu_rsp_valid_i  (fpu_rsp_valid_i),
    .fpu_rsp_tag_i    (fpu_rsp_tag_i),
    .fpu_rsp_result_i (fpu_rsp_result_i),
    .fpu_rsp_flags_i  (fpu_rsp_flags_i),
    .busy_o           (busy_o),
    .proto_err_o      (proto_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    apu_req_i        = 1'b0;
    apu_op_i         = '0;
    apu_operands_i   = '0;
    apu_flags_i      = '0;
    fpu_req_ready_i  = 1'b1;
    fpu_rsp_valid_i  = 1'b0;
    fpu_rsp_tag_i    = 1'b0;
    fpu_rsp_result_i = '0;
    fpu_rsp_flags_i  = '0;
  endtask

  // Advance to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle point for combinational outputs within the current cycle.
  task automatic mid();
    #3;
  endtask

  task automatic rsp(input logic tag, input logic [31:0] res, input logic [4:0] fl);
    fpu_rsp_valid_i  = 1'b1;
    fpu_rsp_tag_i    = tag;
    fpu_rsp_result_i = res;
    fpu_rsp_flags_i  = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 32'(apu_rvalid_o), 32'd0);
    check("rst_result", apu_result_o, 32'd0);
    check("rst_flags",  32'(apu_flags_o), 32'd0);
    check("rst_perr",   32'(proto_err_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_tag",    32'(fpu_tag_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // 1: single op, rsp@3 -> rvalid@5, busy low @6
    do_reset();
    apu_req_i = 1'b1;
    apu_op_i = 6'h15;
    apu_operands_i[0] = 32'h1111_0000;
    apu_operands_i[1] = 32'h2222_0000;
    apu_operands_i[2] = 32'h3333_0000;
    apu_flags_i = 15'h4321;
    mid();
    check("t1_gnt",   32'(apu_gnt_o), 32'd1);
    check("t1_tag",   32'(fpu_tag_o), 32'd0);
    check("t1_op",    32'(fpu_op_o), 32'h15);
    check("t1_opnd1", fpu_operands_o[1], 32'h2222_0000);
    check("t1_dsfl",  32'(fpu_flags_o), 32'h4321);
    tick();
    idle();
    mid();
    check("t1_busy1", 32'(busy_o), 32'd1);
    tick(); tick();
    rsp(1'b0, 32'h3F80_0000, 5'h01);
    mid();
    check("t1_rv3", 32'(apu_rvalid_o), 32'd0);
    tick();
    idle();
    mid();
    check("t1_rv4", 32'(apu_rvalid_o), 32'd0);
    tick();
    mid();
    check("t1_rv5",   32'(apu_rvalid_o), 32'd1);
    check("t1_res5",  apu_result_o, 32'h3F80_0000);
    check("t1_fl5",   32'(apu_flags_o), 32'h01);
    check("t1_busy5", 32'(busy_o), 32'd1);
    tick();
    mid();
    check("t1_rv6",   32'(apu_rvalid_o), 32'd0);
    check("t1_busy6", 32'(busy_o), 32'd0);
    check("t1_hold6", apu_result_o, 32'h3F80_0000);

    // 2: out-of-order completion, in-order return
    do_reset();
    apu_req_i = 1'b1;
    mid();
    check("t2_gnt0", 32'(apu_gnt_o), 32'd1);
    check("t2_tag0", 32'(fpu_tag_o), 32'd0);
    tick();
    mid();
    check("t2_gnt1", 32'(apu_gnt_o), 32'd1);
    check("t2_tag1", 32'(fpu_tag_o), 32'd1);
    tick();
    idle();
    rsp(1'b1, 32'h0000_000A, 5'h02);
    tick();
    idle();
    tick();
    rsp(1'b0, 32'h0000_000B, 5'h04);
    tick();
    idle();
    mid();
    check("t2_rv5", 32'(apu_rvalid_o), 32'd0);
    tick();
    mid();
    check("t2_rv6",  32'(apu_rvalid_o), 32'd1);
    check("t2_res6", apu_result_o, 32'h0000_000B);
    check("t2_fl6",  32'(apu_flags_o), 32'h04);
    tick();
    mid();
    check("t2_rv7",  32'(apu_rvalid_o), 32'd1);
    check("t2_res7", apu_result_o, 32'h0000_000A);
    check("t2_fl7",  32'(apu_flags_o), 32'h02);
    tick();
    mid();
    check("t2_rv8",   32'(apu_rvalid_o), 32'd0);
    check("t2_busy8", 32'(busy_o), 32'd0);
    check("t2_perr",  32'(proto_err_o), 32'd0);

    // 3: full, retire cycle still blocks, grant the cycle after
    do_reset();
    apu_req_i = 1'b1;
    tick();
    tick();
    mid();
    check("t3_gnt2", 32'(apu_gnt_o), 32'd0);
    check("t3_vld2", 32'(fpu_req_valid_o), 32'd0);
    tick();
    rsp(1'b0, 32'h0000_00C0, 5'h00);
    mid();
    check("t3_gnt3", 32'(apu_gnt_o), 32'd0);
    tick();
    fpu_rsp_valid_i = 1'b0;
    mid();
    check("t3_gnt4", 32'(apu_gnt_o), 32'd0);
    tick();
    mid();
    check("t3_gnt5", 32'(apu_gnt_o), 32'd1);
    check("t3_tag5", 32'(fpu_tag_o), 32'd0);
    check("t3_rv5",  32'(apu_rvalid_o), 32'd1);
    check("t3_res5", apu_result_o, 32'h0000_00C0);
    tick();
    apu_req_i = 1'b0;
    mid();
    check("t3_gnt6", 32'(apu_gnt_o), 32'd0);

    // 4: back-pressure from the FPU
    do_reset();
    apu_req_i = 1'b1;
    fpu_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t4_gnt_bp",  32'(apu_gnt_o), 32'd0);
      check("t4_vld_bp",  32'(fpu_req_valid_o), 32'd1);
      check("t4_busy_bp", 32'(busy_o), 32'd0);
      tick();
    end
    fpu_req_ready_i = 1'b1;
    mid();
    check("t4_gnt", 32'(apu_gnt_o), 32'd1);
    check("t4_tag", 32'(fpu_tag_o), 32'd0);
    tick();
    apu_req_i = 1'b0;
    mid();
    check("t4_busy", 32'(busy_o), 32'd1);
    check("t4_tagn", 32'(fpu_tag_o), 32'd1);

    // 5: completion to a free tag (tag0 still outstanding from test 4)
    rsp(1'b1, 32'h0000_0055, 5'h1F);
    tick();
    idle();
    mid();
    check("t5_perr1", 32'(proto_err_o), 32'd1);
    check("t5_rv1",   32'(apu_rvalid_o), 32'd0);
    tick();
    mid();
    check("t5_perr2", 32'(proto_err_o), 32'd1);
    check("t5_rv2",   32'(apu_rvalid_o), 32'd0);
    rsp(1'b0, 32'h0000_0077, 5'h03);
    tick();
    idle();
    tick();
    mid();
    check("t5_rv",   32'(apu_rvalid_o), 32'd1);
    check("t5_res",  apu_result_o, 32'h0000_0077);
    check("t5_fl",   32'(apu_flags_o), 32'h03);
    check("t5_perr", 32'(proto_err_o), 32'd1);

    // 6: reset with two pending entries
    do_reset();
    apu_req_i = 1'b1;
    tick();
    tick();
    apu_req_i = 1'b0;
    mid();
    check("t6_busy_pre", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy_o), 32'd0);
    check("t6_rv",    32'(apu_rvalid_o), 32'd0);
    check("t6_perr0", 32'(proto_err_o), 32'd0);
    check("t6_tag",   32'(fpu_tag_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rsp(1'b0, 32'h0000_0099, 5'h00);
    tick();
    idle();
    mid();
    check("t6_perr", 32'(proto_err_o), 32'd1);
    tick();
    mid();
    check("t6_rv_after", 32'(apu_rvalid_o), 32'd0);
    check("t6_busy_after", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
